neg_mul_sequencer: RTL and testbench

- Multi-cycle signed W x W -> 2W multiplier controller for the KGP-RISC execute stage.
- Sequences the shared 64-bit two's-complement (negation) unit, which is instantiated outside this block. Three uses:
  - fix up the sign of operand A,
  - fix up the sign of operand B,
  - negate the final product when the result is negative.
- Between the B fix-up and the product negation, runs an unsigned shift-add loop.
- Start/busy/done handshake toward the control unit.

---
 rtl/neg_mul_sequencer_if.sv | 20 ++
 rtl/neg_mul_sequencer.sv | 74 +++++++
 tb/tb_neg_mul_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/neg_mul_sequencer_if.sv
// neg_mul_sequencer_if: start/busy/done handshake, operands, product and shared negation-unit link
interface neg_mul_sequencer_if #(parameter int W = 32);
    logic           start;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic           neg_req;
    logic [63:0]    neg_in;
    logic [63:0]    neg_out;
    modport master (
        output start, op_a, op_b, neg_out,
        input  busy, done, product, neg_req, neg_in
    );
    modport slave (
        input  start, op_a, op_b, neg_out,
        output busy, done, product, neg_req, neg_in
    );
endinterface

// File: rtl/neg_mul_sequencer.sv
// neg_mul_sequencer: fixed-latency signed W x W -> 2W multiplier sharing an external negation unit
module neg_mul_sequencer #(
    parameter int W = 32
) (
    input logic clk,
    input logic rst_n,
    neg_mul_sequencer_if.slave bus
);
    localparam int CW = $clog2(W);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] NEG_A = 3'd1;
    localparam logic [2:0] NEG_B = 3'd2;
    localparam logic [2:0] MUL   = 3'd3;
    localparam logic [2:0] NEG_P = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    logic [2:0]     state;
    logic [W-1:0]   a_r, b_r, mag_a, mag_b;
    logic           sign;
    logic [2*W-1:0] acc, product;
    logic [CW-1:0]  cnt;
    assign bus.busy    = state == NEG_A || state == NEG_B || state == MUL || state == NEG_P;
    assign bus.done    = state == DONE;
    assign bus.neg_req = state == NEG_A || state == NEG_B || state == NEG_P;
    assign bus.product = product;
    always_comb begin
        bus.neg_in = state == NEG_A ? 64'(a_r) :
                     state == NEG_B ? 64'(b_r) :
                     state == NEG_P ? 64'(acc) : 64'd0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            sign    <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_r   <= bus.op_a;
                    b_r   <= bus.op_b;
                    sign  <= bus.op_a[W-1] ^ bus.op_b[W-1];
                    state <= NEG_A;
                end
                NEG_A: begin
                    mag_a <= a_r[W-1] ? bus.neg_out[W-1:0] : a_r;
                    state <= NEG_B;
                end
                NEG_B: begin
                    mag_b <= b_r[W-1] ? bus.neg_out[W-1:0] : b_r;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= MUL;
                end
                MUL: begin
                    // -2^(W-1) negates to itself; as an unsigned magnitude it is exact
                    if (mag_b[0]) acc <= acc + ((2*W)'(mag_a) << cnt);
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(W-1)) state <= NEG_P;
                end
                NEG_P: begin
                    product <= sign ? bus.neg_out[2*W-1:0] : acc;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neg_mul_sequencer.sv
// tb_neg_mul_sequencer: directed vectors with hand-computed products, latency and handshake checks
module tb_neg_mul_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int neg_cnt = 0;
    int done_cnt = 0;
    int bad_in = 0;
    neg_mul_sequencer_if #(.W(32)) bus ();
    neg_mul_sequencer #(.W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    assign bus.neg_out = ~bus.neg_in + 64'd1;
    always @(negedge clk) begin
        if (bus.neg_req) neg_cnt++;
        if (bus.done) done_cnt++;
        if (!bus.neg_req && bus.neg_in != 64'd0) bad_in++;
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                       input logic [63:0] prev, input int inj, input string tag);
        int lat;
        neg_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        bus.op_a = a;
        bus.op_b = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        lat = 0;
        for (int n = 1; n <= 100 && lat == 0; n++) begin
            if (n == inj) begin
                bus.start = 1'b1;
                bus.op_a = 32'd9;
                bus.op_b = 32'd9;
            end
            if (n == 20) chk({tag, "_hold"}, bus.product, prev);
            @(posedge clk);
            #1 bus.start = 1'b0;
            if (bus.done) lat = n + 1;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd36);
        chk({tag, "_prod"}, bus.product, exp);
        chk({tag, "_negreq"}, 64'(neg_cnt), 64'd3);
        bus.start = 1'b1;
        bus.op_a = 32'd5;
        bus.op_b = 32'd5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk({tag, "_idle"}, {62'd0, bus.busy, bus.done}, 64'd0);
        chk({tag, "_ndone"}, 64'(done_cnt), 64'd1);
        chk({tag, "_keep"}, bus.product, exp);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        #1;
        chk("rst_out", {60'd0, bus.busy, bus.done, bus.neg_req, |bus.neg_in}, 64'd0);
        chk("rst_prod", bus.product, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run(32'd3, 32'd5, 64'h000000000000000F, 64'd0, 0, "p3x5");
        run(32'hFFFFFFFD, 32'd5, 64'hFFFFFFFFFFFFFFF1, 64'h000000000000000F, 0, "m3x5");
        run(32'hFFFFFFFD, 32'hFFFFFFFB, 64'h000000000000000F, 64'hFFFFFFFFFFFFFFF1, 0, "m3xm5");
        run(32'h80000000, 32'h80000000, 64'h4000000000000000, 64'h000000000000000F, 0, "minxmin");
        run(32'h80000000, 32'd1, 64'hFFFFFFFF80000000, 64'h4000000000000000, 0, "minx1");
        run(32'd0, 32'hFFFFFFF9, 64'd0, 64'hFFFFFFFF80000000, 10, "zero_inj");
        run(32'd7, 32'd6, 64'd42, 64'd0, 0, "p7x6");
        run(32'hFFFFFFFE, 32'd21, 64'hFFFFFFFFFFFFFFD6, 64'd42, 0, "b2b");
        @(negedge clk);
        bus.op_a = 32'd100;
        bus.op_b = 32'd100;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out", {61'd0, bus.busy, bus.done, bus.neg_req}, 64'd0);
        chk("arst_prod", bus.product, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(32'd7, 32'd6, 64'd42, 64'd0, 0, "post_rst");
        chk("neg_in_idle", 64'(bad_in), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
